alu_acc_seq: RTL and testbench
==============================

Name: alu_acc_seq

Overview:
- Parametrised ALU/accumulator for the next-generation CPU datapath.
- Holds a 2W-bit accumulator {acc_high, acc_low} and executes single-cycle logic and arithmetic operations.
- Executes multi-cycle shift-add multiply and restoring divide under an internal sequencer.
- Sits between the control unit (start/op/done handshake) and the register bus (operand).

Parameters:
- W, 4: datapath width; accumulator is 2W bits; W >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- op  input  4  opcode, sampled with start.
- operand  input  W  bus/register operand, sampled with start.
- busy  output  1  high while a MUL/DIV iterates.
- done  output  1  one-cycle completion pulse.
- acc_data  output  2W  {acc_high, acc_low}, registered.
- zero_flag  output  1  result == 0.
- sign_flag  output  1  acc_data[2W-1].
- carry_flag  output  1  carry/borrow/shifted-out bit.
- div_zero_flag  output  1  last DIV had operand == 0.

Behaviour:
- Reset (asynchronous, any state, including mid-MUL/DIV): acc=0, all flags=0, busy=0, done=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, MUL, DIV.
- Handshake:
  - start with busy=0 is accepted at that clock edge.
  - start with busy=1 is ignored: no queueing, no effect.
  - start is also accepted in the cycle done is high.
- Opcodes:
  - 0 NOP
  - 1 LDL: acc_low=operand, acc_high=0.
  - 2 ADD: acc_high=acc_high+operand.
  - 3 SUB: acc_high=acc_high-operand.
  - 4 AND, 5 OR, 6 XOR: acc_high = acc_high op operand.
  - 7 MUL
  - 8 DIV
  - 9 SHL: 2W-bit acc shifted left by 1.
  - 10 SHR: 2W-bit acc shifted right by 1, logical.
  - 11 CLR: acc=0.
  - 12-15: treated as NOP; done still pulses.
- Single-cycle ops: acc and flags update at the accepting edge; done=1 for the next cycle only; busy stays 0.
- MUL: product acc_low*operand, unsigned.
  - Operand is latched at the accepting edge; acc_high is cleared; FSM goes to MUL with busy=1.
  - W iterations, one per cycle: if acc_low[0], add the latched operand to acc_high with a (W+1)-bit carry; then shift {carry, acc_high, acc_low} right by 1.
  - After the Wth iteration: acc = full 2W product, busy=0, done=1 for one cycle, FSM returns to IDLE.
  - done appears W+1 cycles after the accepting edge.
- DIV: unsigned acc_low / operand.
  - acc_high is cleared, divisor latched, FSM goes to DIV, busy=1.
  - W iterations: shift {acc_high, acc_low} left by 1; trial = acc_high - divisor in W+1 bits. If there is no borrow, acc_high=trial and acc_low[0]=1.
  - End result: acc_low = quotient, acc_high = remainder. Same latency as MUL. div_zero_flag=0.
- DIV with operand==0: no iterations, busy stays 0, acc unchanged, div_zero_flag=1, done next cycle.
- Flags: updated only on operation completion; NOP/illegal opcodes leave all flags unchanged.
  - zero_flag = (new acc_data == 0).
  - sign_flag = new acc_data[2W-1].
  - carry_flag:
    - ADD: carry-out.
    - SUB: borrow (acc_high < operand).
    - SHL: old acc[2W-1]; SHR: old acc[0].
    - All other ops: 0.
  - div_zero_flag is written only by DIV.
- Arithmetic wraps modulo 2^W in acc_high; acc_low is not affected by ADD/SUB/logic ops.
- Intermediate acc values during MUL/DIV are visible on acc_data; consumers must wait for done.

Optional Feature:
- Macro ACC_ALU_SAT_EN.
- Defined:
  - ADD overflow saturates acc_high to all ones, with carry_flag=1.
  - SUB underflow saturates acc_high to 0, with carry_flag=1.
- Undefined: modulo wrap as described in Behaviour; no saturation logic is synthesised.

Test Plan:
- W=4: LDL 7, then MUL 6 -> busy high 4 cycles, done 5 cycles after accept, acc_data=0x2A, zero=0, carry=0.
- W=4: LDL 13, then DIV 3 -> acc_data=0x14 (remainder 1, quotient 4), div_zero_flag=0, done after 5 cycles.
- DIV 0 with acc=0x05 -> done next cycle, busy never high, acc_data=0x05, div_zero_flag=1.
- acc_high=0xF, ADD 1 -> acc_high=0x0, carry=1 (0xF with carry=1 under ACC_ALU_SAT_EN); SUB 5 from acc_high=0x2 -> 0xD, carry=1 (0x0 with carry=1 under ACC_ALU_SAT_EN).
- start MUL, pulse start again at cycle 2 (ignored); assert reset_n=0 at cycle 3 -> acc=0, busy=0, done=0 immediately; after release, LDL 3 completes normally.
- W=8: LDL 0xFF, MUL 0xFF -> acc_data=0xFE01 after 9 cycles; SHL -> carry=1, acc_data=0xFC02.

Source files
------------

// File: rtl/alu_acc_seq_if.sv
// Control/register-bus bundle for alu_acc_seq: start/op/operand in, busy/done/accumulator/flags out.
// The control unit drives the master side; the ALU presents the slave side.
interface alu_acc_seq_if #(
  parameter int W = 4
);
  logic           start;
  logic [3:0]     op;
  logic [W-1:0]   operand;
  logic           busy;
  logic           done;
  logic [2*W-1:0] acc_data;
  logic           zero_flag;
  logic           sign_flag;
  logic           carry_flag;
  logic           div_zero_flag;

  modport master (
    output start, op, operand,
    input  busy, done, acc_data, zero_flag, sign_flag, carry_flag, div_zero_flag
  );

  modport slave (
    input  start, op, operand,
    output busy, done, acc_data, zero_flag, sign_flag, carry_flag, div_zero_flag
  );
endinterface

// File: rtl/alu_acc_seq.sv
// 2W-bit ALU/accumulator: logic/arith ops done 1 cycle after accept, MUL/DIV done W+1 cycles after accept.
// start is ignored (not queued) while busy; ACC_ALU_SAT_EN makes ADD/SUB saturate instead of wrap.
module alu_acc_seq #(
  parameter int W = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_acc_seq_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  localparam logic [3:0] OP_LDL = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;
  localparam logic [3:0] OP_DIV = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;
  localparam logic [3:0] OP_SHR = 4'd10;
  localparam logic [3:0] OP_CLR = 4'd11;

  localparam int CW = $clog2(W + 1);

  state_t          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;
  logic            zero_q, zero_d;
  logic            sign_q, sign_d;
  logic            carry_q, carry_d;
  logic            dz_q, dz_d;
  logic            fin;
  logic [W:0]      alu_ext;

  logic [W-1:0]    acc_hi, acc_lo;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_rem;
  logic [W-1:0]    div_trial;
  logic            div_ge;
  logic [2*W-1:0]  div_next;
  logic            last_iter;

  assign acc_hi = acc_q[2*W-1:W];
  assign acc_lo = acc_q[W-1:0];

  // Shift-add multiply step: conditional add into the high half, then shift {carry, hi, lo} right.
  assign mul_sum  = acc_q[0] ? ({1'b0, acc_hi} + {1'b0, opnd_q}) : {1'b0, acc_hi};
  assign mul_next = {mul_sum, acc_lo[W-1:1]};

  // Restoring divide step; the partial remainder keeps the bit shifted out of acc_high.
  assign div_rem   = {acc_hi, acc_lo[W-1]};
  assign div_ge    = (div_rem >= {1'b0, opnd_q});
  assign div_trial = div_rem[W-1:0] - opnd_q;
  assign div_next  = div_ge ? {div_trial, acc_lo[W-2:0], 1'b1}
                            : {div_rem[W-1:0], acc_lo[W-2:0], 1'b0};

  assign last_iter = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    carry_d = carry_q;
    dz_d    = dz_q;
    fin     = 1'b0;
    alu_ext = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          done_d  = 1'b1;
          fin     = 1'b1;
          carry_d = 1'b0;
          case (bus.op)
            OP_LDL: acc_d = {{W{1'b0}}, bus.operand};
            OP_ADD: begin
              alu_ext = {1'b0, acc_hi} + {1'b0, bus.operand};
              carry_d = alu_ext[W];
              acc_d[2*W-1:W] = alu_ext[W-1:0];
`ifdef ACC_ALU_SAT_EN
              if (alu_ext[W]) acc_d[2*W-1:W] = '1;
`endif
            end
            OP_SUB: begin
              alu_ext = {1'b0, acc_hi} - {1'b0, bus.operand};
              carry_d = alu_ext[W];
              acc_d[2*W-1:W] = alu_ext[W-1:0];
`ifdef ACC_ALU_SAT_EN
              if (alu_ext[W]) acc_d[2*W-1:W] = '0;
`endif
            end
            OP_AND: acc_d[2*W-1:W] = acc_hi & bus.operand;
            OP_OR:  acc_d[2*W-1:W] = acc_hi | bus.operand;
            OP_XOR: acc_d[2*W-1:W] = acc_hi ^ bus.operand;
            OP_MUL: begin
              done_d  = 1'b0;
              fin     = 1'b0;
              carry_d = carry_q;
              acc_d   = {{W{1'b0}}, acc_lo};
              opnd_d  = bus.operand;
              cnt_d   = '0;
              state_d = S_MUL;
            end
            OP_DIV: begin
              if (bus.operand == '0) begin
                dz_d = 1'b1;
              end else begin
                done_d  = 1'b0;
                fin     = 1'b0;
                carry_d = carry_q;
                acc_d   = {{W{1'b0}}, acc_lo};
                opnd_d  = bus.operand;
                cnt_d   = '0;
                state_d = S_DIV;
              end
            end
            OP_SHL: begin
              carry_d = acc_q[2*W-1];
              acc_d   = {acc_q[2*W-2:0], 1'b0};
            end
            OP_SHR: begin
              carry_d = acc_q[0];
              acc_d   = {1'b0, acc_q[2*W-1:1]};
            end
            OP_CLR: acc_d = '0;
            // NOP and the unused opcodes still pulse done but leave flags alone.
            default: begin
              fin     = 1'b0;
              carry_d = carry_q;
            end
          endcase
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          fin     = 1'b1;
          carry_d = 1'b0;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          fin     = 1'b1;
          carry_d = 1'b0;
          dz_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    zero_d = fin ? (acc_d == '0) : zero_q;
    sign_d = fin ? acc_d[2*W-1] : sign_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      sign_q  <= 1'b0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
      sign_q  <= sign_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy          = (state_q != S_IDLE);
  assign bus.done          = done_q;
  assign bus.acc_data      = acc_q;
  assign bus.zero_flag     = zero_q;
  assign bus.sign_flag     = sign_q;
  assign bus.carry_flag    = carry_q;
  assign bus.div_zero_flag = dz_q;
endmodule

// File: tb/tb_alu_acc_seq.sv
// Bench for alu_acc_seq: directed vector table, multi-cycle corner sequences, W=8 spot check,
// and random ops against an arithmetic reference model.
module tb_alu_acc_seq;
  localparam int W  = 4;
  localparam int W8 = 8;

`ifdef ACC_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [3:0] NOP = 4'd0,  LDL = 4'd1,  ADD = 4'd2,  SUB = 4'd3;
  localparam logic [3:0] AND = 4'd4,  OR  = 4'd5,  XOR = 4'd6,  MUL = 4'd7;
  localparam logic [3:0] DIV = 4'd8,  SHL = 4'd9,  SHR = 4'd10, CLR = 4'd11;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_acc_seq_if #(.W(W))  ifa();
  alu_acc_seq_if #(.W(W8)) ifb();

  alu_acc_seq #(.W(W))  dut  (.clk(clk), .reset_n(reset_n), .bus(ifa));
  alu_acc_seq #(.W(W8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(ifb));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]     op;
    logic [W-1:0]   opnd;
    logic [2*W-1:0] acc;
    logic           c;
    logic           dz;
    int             lat;
  } vec_t;
  vec_t tbl[$];

  // Reference model state
  logic [2*W-1:0] m_acc;
  logic m_z, m_s, m_c, m_dz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] v, input logic [2*W-1:0] acc,
                         input logic c, input logic dz, input int lat);
    vec_t r;
    r.op = op; r.opnd = v; r.acc = acc; r.c = c; r.dz = dz; r.lat = lat;
    tbl.push_back(r);
  endtask

  task automatic model_reset();
    m_acc = '0; m_z = 1'b0; m_s = 1'b0; m_c = 1'b0; m_dz = 1'b0;
  endtask

  task automatic model_apply(input logic [3:0] op, input logic [W-1:0] v, output int lat);
    int hi, lo, x, md, full;
    bit fin;
    hi = int'(m_acc[2*W-1:W]);
    lo = int'(m_acc[W-1:0]);
    x  = int'(v);
    md = 1 << W;
    fin = 1'b1;
    lat = 1;
    case (op)
      LDL: begin hi = 0; lo = x; m_c = 1'b0; end
      ADD: begin
        m_c = (hi + x) >= md;
        hi  = m_c ? (SAT ? md - 1 : hi + x - md) : hi + x;
      end
      SUB: begin
        m_c = hi < x;
        hi  = m_c ? (SAT ? 0 : hi - x + md) : hi - x;
      end
      AND: begin hi = hi & x; m_c = 1'b0; end
      OR:  begin hi = hi | x; m_c = 1'b0; end
      XOR: begin hi = hi ^ x; m_c = 1'b0; end
      MUL: begin
        full = lo * x; hi = full / md; lo = full % md; m_c = 1'b0; lat = W + 1;
      end
      DIV: begin
        m_c = 1'b0;
        if (x == 0) m_dz = 1'b1;
        else begin hi = lo % x; lo = lo / x; m_dz = 1'b0; lat = W + 1; end
      end
      SHL: begin
        full = hi * md + lo;
        m_c  = full >= (md * md) / 2;
        full = (full * 2) % (md * md);
        hi = full / md; lo = full % md;
      end
      SHR: begin
        full = hi * md + lo;
        m_c  = (full % 2) == 1;
        full = full / 2;
        hi = full / md; lo = full % md;
      end
      CLR: begin hi = 0; lo = 0; m_c = 1'b0; end
      default: fin = 1'b0;
    endcase
    m_acc = {W'(hi), W'(lo)};
    if (fin) begin
      m_z = (m_acc == '0);
      m_s = m_acc[2*W-1];
    end
  endtask

  // Issue one op and wait (bounded) for its done pulse; returns latency and busy-cycle count.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] v, output int lat, output int bcnt);
    @(negedge clk);
    ifa.start = 1'b1; ifa.op = op; ifa.operand = v;
    @(negedge clk);
    ifa.start = 1'b0;
    lat = 1; bcnt = 0;
    while (ifa.done !== 1'b1 && lat < 40) begin
      if (ifa.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_model(input string tag, input int lat, input int mlat, input int bcnt);
    check({tag, "_acc"},   64'(ifa.acc_data),      64'(m_acc));
    check({tag, "_zero"},  64'(ifa.zero_flag),     64'(m_z));
    check({tag, "_sign"},  64'(ifa.sign_flag),     64'(m_s));
    check({tag, "_carry"}, 64'(ifa.carry_flag),    64'(m_c));
    check({tag, "_dz"},    64'(ifa.div_zero_flag), 64'(m_dz));
    check({tag, "_lat"},   64'(lat),               64'(mlat));
    check({tag, "_busy"},  64'(bcnt),              64'((mlat == W + 1) ? W : 0));
  endtask

  initial begin
    int lat, bcnt, mlat;
    logic [3:0] rop;
    logic [W-1:0] rv;

    ifa.start = 1'b0; ifa.op = '0; ifa.operand = '0;
    ifb.start = 1'b0; ifb.op = '0; ifb.operand = '0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_acc",   64'(ifa.acc_data),      64'd0);
    check("rst_busy",  64'(ifa.busy),          64'd0);
    check("rst_done",  64'(ifa.done),          64'd0);
    check("rst_zero",  64'(ifa.zero_flag),     64'd0);
    check("rst_sign",  64'(ifa.sign_flag),     64'd0);
    check("rst_carry", 64'(ifa.carry_flag),    64'd0);
    check("rst_dz",    64'(ifa.div_zero_flag), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // op, operand, expected acc, carry, div_zero, latency
    add_vec(CLR, 4'h0, 8'h00, 1'b0, 1'b0, 1);
    add_vec(LDL, 4'h7, 8'h07, 1'b0, 1'b0, 1);
    add_vec(MUL, 4'h6, 8'h2A, 1'b0, 1'b0, 5);
    add_vec(LDL, 4'hD, 8'h0D, 1'b0, 1'b0, 1);
    add_vec(DIV, 4'h3, 8'h14, 1'b0, 1'b0, 5);
    add_vec(LDL, 4'h5, 8'h05, 1'b0, 1'b0, 1);
    add_vec(DIV, 4'h0, 8'h05, 1'b0, 1'b1, 1);
    add_vec(LDL, 4'h0, 8'h00, 1'b0, 1'b1, 1);
    add_vec(ADD, 4'hF, 8'hF0, 1'b0, 1'b1, 1);
    add_vec(ADD, 4'h1, SAT ? 8'hF0 : 8'h00, 1'b1, 1'b1, 1);
    add_vec(CLR, 4'h0, 8'h00, 1'b0, 1'b1, 1);
    add_vec(ADD, 4'h2, 8'h20, 1'b0, 1'b1, 1);
    add_vec(SUB, 4'h5, SAT ? 8'h00 : 8'hD0, 1'b1, 1'b1, 1);
    add_vec(LDL, 4'h9, 8'h09, 1'b0, 1'b1, 1);
    add_vec(SHL, 4'h0, 8'h12, 1'b0, 1'b1, 1);
    add_vec(SHR, 4'h0, 8'h09, 1'b0, 1'b1, 1);
    add_vec(SHR, 4'h0, 8'h04, 1'b1, 1'b1, 1);
    add_vec(NOP, 4'h3, 8'h04, 1'b1, 1'b1, 1);
    add_vec(4'd13, 4'h3, 8'h04, 1'b1, 1'b1, 1);
    add_vec(LDL, 4'h6, 8'h06, 1'b0, 1'b1, 1);
    add_vec(ADD, 4'hC, 8'hC6, 1'b0, 1'b1, 1);
    add_vec(AND, 4'hA, 8'h86, 1'b0, 1'b1, 1);
    add_vec(OR,  4'h3, 8'hB6, 1'b0, 1'b1, 1);
    add_vec(XOR, 4'hF, 8'h46, 1'b0, 1'b1, 1);
    add_vec(DIV, 4'h4, 8'h21, 1'b0, 1'b0, 5);

    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i].op, tbl[i].opnd, lat, bcnt);
      model_apply(tbl[i].op, tbl[i].opnd, mlat);
      check($sformatf("vec%0d_acc", i),   64'(ifa.acc_data),      64'(tbl[i].acc));
      check($sformatf("vec%0d_carry", i), 64'(ifa.carry_flag),    64'(tbl[i].c));
      check($sformatf("vec%0d_dz", i),    64'(ifa.div_zero_flag), 64'(tbl[i].dz));
      check($sformatf("vec%0d_zero", i),  64'(ifa.zero_flag),     64'(tbl[i].acc == '0));
      check($sformatf("vec%0d_sign", i),  64'(ifa.sign_flag),     64'(tbl[i].acc[2*W-1]));
      check($sformatf("vec%0d_lat", i),   64'(lat),               64'(tbl[i].lat));
      check($sformatf("vec%0d_bcnt", i),  64'(bcnt),              64'((tbl[i].lat == W + 1) ? W : 0));
      check($sformatf("vec%0d_busy", i),  64'(ifa.busy),          64'd0);
    end

    // start held high while busy must be ignored; done is a single-cycle pulse.
    run_op(LDL, 4'h7, lat, bcnt);
    model_apply(LDL, 4'h7, mlat);
    @(negedge clk);
    ifa.start = 1'b1; ifa.op = MUL; ifa.operand = 4'h6;
    model_apply(MUL, 4'h6, mlat);
    @(negedge clk);
    ifa.op = CLR; lat = 1;
    @(negedge clk);
    ifa.start = 1'b0; lat = 2;
    while (ifa.done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check("ign_lat", 64'(lat), 64'(W + 1));
    check("ign_acc", 64'(ifa.acc_data), 64'h2A);
    @(negedge clk);
    check("ign_done_pulse", 64'(ifa.done), 64'd0);
    check("ign_acc_hold", 64'(ifa.acc_data), 64'h2A);

    // start accepted in the cycle done is high
    @(negedge clk);
    ifa.start = 1'b1; ifa.op = LDL; ifa.operand = 4'h2;
    model_apply(LDL, 4'h2, mlat);
    @(negedge clk);
    check("b2b_done1", 64'(ifa.done), 64'd1);
    ifa.op = ADD; ifa.operand = 4'h3;
    model_apply(ADD, 4'h3, mlat);
    @(negedge clk);
    ifa.start = 1'b0;
    check("b2b_done2", 64'(ifa.done), 64'd1);
    check("b2b_acc", 64'(ifa.acc_data), 64'h32);
    check_model("b2b", 1, 1, 0);

    // reset in the middle of a MUL, with an ignored start beforehand
    @(negedge clk);
    ifa.start = 1'b1; ifa.op = MUL; ifa.operand = 4'h5;
    @(negedge clk);
    ifa.start = 1'b0;
    @(negedge clk);
    ifa.start = 1'b1; ifa.op = LDL; ifa.operand = 4'h9;
    @(negedge clk);
    ifa.start = 1'b0;
    check("mid_busy", 64'(ifa.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_acc",  64'(ifa.acc_data), 64'd0);
    check("mid_rst_busy", 64'(ifa.busy),     64'd0);
    check("mid_rst_done", 64'(ifa.done),     64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    run_op(LDL, 4'h3, lat, bcnt);
    model_apply(LDL, 4'h3, mlat);
    check("post_rst_acc", 64'(ifa.acc_data), 64'h03);
    check("post_rst_lat", 64'(lat), 64'd1);

    // W=8 instance
    @(negedge clk);
    ifb.start = 1'b1; ifb.op = LDL; ifb.operand = 8'hFF;
    @(negedge clk);
    ifb.start = 1'b0;
    check("w8_ldl", 64'(ifb.acc_data), 64'h00FF);
    @(negedge clk);
    ifb.start = 1'b1; ifb.op = MUL; ifb.operand = 8'hFF;
    @(negedge clk);
    ifb.start = 1'b0; lat = 1;
    while (ifb.done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    check("w8_mul_lat",  64'(lat), 64'd9);
    check("w8_mul_acc",  64'(ifb.acc_data), 64'hFE01);
    check("w8_mul_sign", 64'(ifb.sign_flag), 64'd1);
    check("w8_mul_c",    64'(ifb.carry_flag), 64'd0);
    @(negedge clk);
    ifb.start = 1'b1; ifb.op = SHL; ifb.operand = 8'h00;
    @(negedge clk);
    ifb.start = 1'b0;
    check("w8_shl_acc", 64'(ifb.acc_data), 64'hFC02);
    check("w8_shl_c",   64'(ifb.carry_flag), 64'd1);

    // random ops against the reference model
    for (int n = 0; n < 250; n++) begin
      rop = 4'($urandom_range(0, 15));
      rv  = W'($urandom_range(0, (1 << W) - 1));
      if (n % 7 == 0) rv = '0;
      model_apply(rop, rv, mlat);
      run_op(rop, rv, lat, bcnt);
      check_model($sformatf("rnd%0d_op%0d", n, rop), lat, mlat, bcnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
